// File: rtl/divisor_secuencial_8bits.sv
// divisor_secuencial_8bits: 8-bit unsigned restoring divider, one quotient bit per clock.
// A start accepted in IDLE captures A/B; eight CALC cycles follow, then a FIN cycle with done.
// Optional divide-by-zero flag port err is compiled in with macro DIVISOR_CERO_EN.
// Divide by zero falls out of the algorithm itself: Q = 8'hFF, R = A.
module divisor_secuencial_8bits (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic       busy,
    output logic       done
`ifdef DIVISOR_CERO_EN
    ,
    output logic       err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Result of one restoring step: new partial remainder and the quotient bit produced.
    typedef struct packed {
        logic [8:0] rem;
        logic       qbit;
    } step_t;

    // One restoring-division step. The trial subtraction is 9 bits plus a borrow bit,
    // so a shifted remainder of 128..255 still compares correctly against the divisor.
    // A set bit 8 on the incoming remainder would mean the value already exceeds
    // any 8-bit divisor, so it forces the subtract.
    function automatic step_t restoring_step(input logic [8:0] rem_in,
                                             input logic       dividend_bit,
                                             input logic [7:0] divisor);
        step_t      res;
        logic [8:0] shifted;
        logic [9:0] trial;
        logic       ge;
        shifted = {rem_in[7:0], dividend_bit};
        trial   = {1'b0, shifted} - {2'b00, divisor};
        ge      = rem_in[8] | ~trial[9];
        if (ge) begin
            res.rem = trial[8:0];
        end else begin
            res.rem = shifted;
        end
        res.qbit = ge;
        return res;
    endfunction

    // State and datapath registers.
    state_t     state_q, state_d;
    logic [2:0] cnt_q,   cnt_d;     // remaining steps after the current one
    logic [7:0] aq_q,    aq_d;      // dividend bits shift out the top, quotient bits in at the bottom
    logic [7:0] b_q,     b_d;       // captured divisor
    logic [8:0] rem_q,   rem_d;     // partial remainder
    logic [7:0] q_out_q, q_out_d;
    logic [7:0] r_out_q, r_out_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;
`ifdef DIVISOR_CERO_EN
    logic       err_q,   err_d;
`endif

    step_t      step_s;
    logic [7:0] aq_step_s;

    // Combinational step datapath driven from the current registers.
    always_comb begin
        step_s    = restoring_step(rem_q, aq_q[7], b_q);
        aq_step_s = {aq_q[6:0], step_s.qbit};
    end

    // Next-state and next-output logic for the IDLE/CALC/FIN sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        aq_d    = aq_q;
        b_d     = b_q;
        rem_d   = rem_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef DIVISOR_CERO_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    aq_d    = A;
                    b_d     = B;
                    rem_d   = 9'd0;
                    cnt_d   = 3'd7;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                aq_d  = aq_step_s;
                rem_d = step_s.rem;
                if (cnt_q == 3'd0) begin
                    // Last step: publish results together with the done pulse.
                    state_d = FIN;
                    q_out_d = aq_step_s;
                    r_out_d = step_s.rem[7:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
`ifdef DIVISOR_CERO_EN
                    err_d   = (b_q == 8'd0);
`endif
                end else begin
                    cnt_d  = cnt_q - 3'd1;
                    busy_d = 1'b1;
                end
            end
            FIN: begin
                // start is deliberately not looked at here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset that aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            aq_q    <= 8'd0;
            b_q     <= 8'd0;
            rem_q   <= 9'd0;
            q_out_q <= 8'd0;
            r_out_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIVISOR_CERO_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            aq_q    <= aq_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIVISOR_CERO_EN
            err_q   <= err_d;
`endif
        end
    end

    assign Q    = q_out_q;
    assign R    = r_out_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef DIVISOR_CERO_EN
    assign err  = err_q;
`endif

endmodule
